mem_sp_ctrl: RTL



---
 rtl/mem_sp_ctrl.sv | 100 ++++++++++
 1 files changed

// File: rtl/mem_sp_ctrl.sv
// Single-port synchronous memory with req/ready handshake, pipelined read data and a post-reset clear engine.
// Optional build macro MEM_PARITY_EN adds one stored even-parity bit per word and a parity_err flag.
module mem_sp_ctrl #(
   parameter     INIT_FILE   = "mem_init.mif",
   parameter int ADDR_WIDTH  = 6,
   parameter int DATA_WIDTH  = 16,
   parameter int CLEAR_WORDS = 8,
   parameter int RD_LATENCY  = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  err_inject,
   output logic                  ready,
   output logic                  rvalid,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  init_busy,
   output logic                  parity_err
);

   localparam int DEPTH     = 2**ADDR_WIDTH;
   localparam bit HAS_CLEAR = (CLEAR_WORDS > 0);
   localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(HAS_CLEAR ? CLEAR_WORDS - 1 : 0);
`ifdef MEM_PARITY_EN
   localparam int MW = DATA_WIDTH + 1;
`else
   localparam int MW = DATA_WIDTH;
`endif

   localparam logic [0:0] S_INIT = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   logic [0:0]            state;
   logic [ADDR_WIDTH-1:0] ptr;
   logic [MW-1:0]         mem [DEPTH];
   logic [MW-1:0]         wword;
   logic [MW-1:0]         rword;
   logic                  rd_perr;
   logic                  wr_acc;
   logic                  rd_acc;

   assign ready     = (state == S_RUN);
   assign init_busy = (state == S_INIT) && HAS_CLEAR;
   assign wr_acc    = req & ready & we;
   assign rd_acc    = req & ready & ~we;
   assign rword     = mem[addr];

`ifdef MEM_PARITY_EN
   assign wword   = {(^wdata) ^ err_inject, wdata};
   assign rd_perr = ^rword;
`else
   logic unused_err_inject;
   assign unused_err_inject = err_inject;
   assign wword   = wdata;
   assign rd_perr = 1'b0;
`endif

   // With no clear region the FSM still spends the reset cycle in INIT so ready stays low through reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_INIT;
         ptr   <= '0;
      end else if (state == S_INIT) begin
         if (!HAS_CLEAR || ptr == LAST_PTR) state <= S_RUN;
         else                               ptr   <= ptr + 1'b1;
      end
   end

   // A zero word has even parity 0, so an all-zero store is correct in both builds.
   always_ff @(posedge clk) begin
      if (init_busy)   mem[ptr]  <= '0;
      else if (wr_acc) mem[addr] <= wword;
   end

   logic [RD_LATENCY-1:0] vld_pipe;
   logic [DATA_WIDTH:0]   dat_pipe [RD_LATENCY];

   // Data stages only load on a valid beat so rdata holds its last value between reads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         for (int i = 0; i < RD_LATENCY; i++) dat_pipe[i] <= '0;
      end else begin
         vld_pipe[0] <= rd_acc;
         if (rd_acc) dat_pipe[0] <= {rd_perr, rword[DATA_WIDTH-1:0]};
         for (int i = 1; i < RD_LATENCY; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            if (vld_pipe[i-1]) dat_pipe[i] <= dat_pipe[i-1];
         end
      end
   end

   assign rvalid     = vld_pipe[RD_LATENCY-1];
   assign rdata      = dat_pipe[RD_LATENCY-1][DATA_WIDTH-1:0];
   assign parity_err = rvalid & dat_pipe[RD_LATENCY-1][DATA_WIDTH];

endmodule
